pll_lock_seq: RTL and testbench
===============================

# pll_lock_seq

Lock qualifier and system-reset sequencer for the PLL wrapper's `lock` output.
- Samples the asynchronous `lock` on the free-running `mdclk` domain and debounces it.
- Holds the design in reset until lock has been stable for a programmable time.
- Requests a PLL re-initialisation (into the wrapper's init `I_RST`) when lock does not arrive within a timeout.
- Latches a failure flag after too many retries.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth on `lock_in`, minimum 2.
- LOCK_STABLE, 1024: consecutive high `lock_s` cycles required before qualification.
- RST_HOLD, 16: extra cycles `sys_rst` stays high after qualification.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry.
- RETRY_PULSE, 8: width of the `pll_rst` pulse, in cycles.
- MAX_RETRY, 4: number of retries before FAIL.
- RCNT_W, 3: width of `retry_cnt`; must hold MAX_RETRY.

Ports:
- clk  in  1  `mdclk` domain (50 MHz reference); the only clock.
- rst  in  1  synchronous, active-high reset.
- lock_in  in  1  raw PLL lock, asynchronous.
- pll_rst  out  1  re-init request to the PLL init stage.
- sys_rst  out  1  synchronous active-high reset for downstream logic.
- ready  out  1  lock qualified, `sys_rst` released.
- lost_lock  out  1  one-cycle pulse on lock loss while in RUN.
- fail  out  1  sticky; MAX_RETRY retries exhausted.
- retry_cnt  out  RCNT_W  retries since the last RUN entry.

## Operation
- The only clock is `clk`; reset is synchronous and active-high.
- `lock_s` is `lock_in` passed through SYNC_STAGES flops. There is no other filtering.
- The state register (WAIT_LOCK, HOLD, RUN, RETRY, FAIL) plus `tcnt` (timeout/hold/pulse counter) and `scnt` (stable counter) are the only sequential state besides the synchroniser.
- WAIT_LOCK:
  - `sys_rst`=1, `pll_rst`=0.
  - `scnt` increments while `lock_s`=1 and clears to 0 when `lock_s`=0.
  - When `scnt`=LOCK_STABLE-1 and `lock_s`=1, go to HOLD and clear `tcnt`.
  - Otherwise, when `tcnt`=LOCK_TIMEOUT-1:
    - if `retry_cnt`=MAX_RETRY, go to FAIL;
    - else go to RETRY and increment `retry_cnt`.
  - Qualification takes priority over timeout when both occur in the same cycle.
- HOLD:
  - `sys_rst`=1; `tcnt` counts.
  - `lock_s`=0 returns to WAIT_LOCK with counters cleared and no `lost_lock` pulse.
  - At `tcnt`=RST_HOLD-1, go to RUN.
- RUN:
  - `sys_rst`=0, `ready`=1, `retry_cnt` cleared on entry.
  - `lock_s`=0 → WAIT_LOCK, with `sys_rst`=1, `ready`=0 and `lost_lock`=1 all registered on that transition.
- RETRY:
  - `pll_rst`=1 for exactly RETRY_PULSE cycles, then WAIT_LOCK with counters cleared.
  - `lock_s` is ignored in this state.
- FAIL:
  - `sys_rst`=1, `pll_rst`=0, `fail`=1. Exit only on `rst`.
- Counters:
  - `tcnt` is clog2(max(LOCK_TIMEOUT, RST_HOLD, RETRY_PULSE)) bits; `scnt` is clog2(LOCK_STABLE) bits.
  - Neither counter ever wraps; both clear on every state change.
- All outputs are registered.

## Timing
- Reset values: `sys_rst`=1, `pll_rst`=0, `ready`=0, `lost_lock`=0, `fail`=0, `retry_cnt`=0, state=WAIT_LOCK, counters=0.
- Latency from a `lock_in` rise to `ready`: SYNC_STAGES + LOCK_STABLE + RST_HOLD cycles, with `lock_in` held steady high.
- Latency from a `lock_in` fall in RUN to `sys_rst`=1: SYNC_STAGES + 1 cycles.
- A glitch low of at least one sampled cycle restarts `scnt` from 0.
- `rst` mid-pulse ends `pll_rst` on the next edge.
- `lost_lock` never lasts more than one cycle.
- `ready` and `sys_rst` are always complementary.

## Structure
- Shared package `pll_seq_pkg`:
  - state enum `pll_seq_state_t`;
  - default parameter constants;
  - a clog2-based counter-width function.
- Sub-module `sync_ff`: parameterised SYNC_STAGES flop chain, reset value 0. It is reused for other async status inputs.

## Test plan
All scenarios use SYNC_STAGES=2, LOCK_STABLE=8, RST_HOLD=4, LOCK_TIMEOUT=32, RETRY_PULSE=3, MAX_RETRY=2.
- Clean lock: release `rst`, raise `lock_in` at cycle 0 → `ready`=1 and `sys_rst`=0 at cycle 14; `pll_rst` never asserted.
- Glitch: `lock_in` high, then low for 1 cycle at cycle 5, then high → `ready` delayed to 14 cycles after the re-rise.
- Timeout/retry: `lock_in` held low → `pll_rst` high for 3 cycles after 32 WAIT_LOCK cycles, `retry_cnt`=1; then lock → RUN, `retry_cnt`=0.
- Fail: `lock_in` never high → two retry pulses, third timeout → `fail`=1, `sys_rst`=1, no further `pll_rst`; `rst` clears `fail`.
- Loss in RUN: drop `lock_in` → `sys_rst`=1 and a one-cycle `lost_lock` 3 cycles later; loss during HOLD → no `lost_lock`.
- Reset during RETRY: assert `rst` on pulse cycle 2 → `pll_rst`=0 on the next edge, all outputs at reset values.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : pll_seq_pkg                                                     |
// | Purpose  : Shared types, default constants and counter sizing for the      |
// |            PLL lock qualifier / system-reset sequencer.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_RETRY     = 3'd3,
        ST_FAIL      = 3'd4
    } pll_seq_state_t;

    localparam int c_def_sync_stages  = 2;
    localparam int c_def_lock_stable  = 1024;
    localparam int c_def_rst_hold     = 16;
    localparam int c_def_lock_timeout = 65536;
    localparam int c_def_retry_pulse  = 8;
    localparam int c_def_max_retry    = 4;
    localparam int c_def_rcnt_w       = 3;

    // Width of a counter that must reach max_count-1; never narrower than 1 bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// +----------------------------------------------------------------------------+
// | Module   : sync_ff                                                         |
// | Purpose  : Multi-stage flop chain for bringing asynchronous status bits    |
// |            into the clk domain; clears to 0 on reset.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_lock_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : pll_lock_seq                                                    |
// | Purpose  : Qualifies the PLL lock, sequences the downstream system reset   |
// |            and requests PLL re-initialisation on lock timeout.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module pll_lock_seq
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES  = c_def_sync_stages,
    parameter int LOCK_STABLE  = c_def_lock_stable,
    parameter int RST_HOLD     = c_def_rst_hold,
    parameter int LOCK_TIMEOUT = c_def_lock_timeout,
    parameter int RETRY_PULSE  = c_def_retry_pulse,
    parameter int MAX_RETRY    = c_def_max_retry,
    parameter int RCNT_W       = c_def_rcnt_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lock_in,
    output logic              pll_rst,
    output logic              sys_rst,
    output logic              ready,
    output logic              lost_lock,
    output logic              fail,
    output logic [RCNT_W-1:0] retry_cnt
);

    localparam int c_tcnt_w = cnt_width(max3(LOCK_TIMEOUT, RST_HOLD, RETRY_PULSE));
    localparam int c_scnt_w = cnt_width(LOCK_STABLE);

    localparam logic [c_tcnt_w-1:0] c_timeout_last = c_tcnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_tcnt_w-1:0] c_hold_last    = c_tcnt_w'(RST_HOLD - 1);
    localparam logic [c_tcnt_w-1:0] c_pulse_last   = c_tcnt_w'(RETRY_PULSE - 1);
    localparam logic [c_scnt_w-1:0] c_stable_last  = c_scnt_w'(LOCK_STABLE - 1);
    localparam logic [RCNT_W-1:0]   c_max_retry    = RCNT_W'(MAX_RETRY);

    logic                w_lock_s;
    pll_seq_state_t      r_state;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic [c_scnt_w-1:0] r_scnt;
    logic                r_pll_rst;
    logic                r_sys_rst;
    logic                r_ready;
    logic                r_lost_lock;
    logic                r_fail;
    logic [RCNT_W-1:0]   r_retry_cnt;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (lock_in),
        .o_q (w_lock_s)
    );

    // Outputs are updated on the same edge as the state transition that
    // implies them, so every output is a flop with no decode after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_WAIT_LOCK;
            r_tcnt      <= '0;
            r_scnt      <= '0;
            r_pll_rst   <= 1'b0;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lost_lock <= 1'b0;
            r_fail      <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            r_lost_lock <= 1'b0;
            case (r_state)
                ST_WAIT_LOCK: begin
                    // Qualification wins when it coincides with the timeout.
                    if (w_lock_s && (r_scnt == c_stable_last)) begin
                        r_state <= ST_HOLD;
                        r_tcnt  <= '0;
                        r_scnt  <= '0;
                    end else if (r_tcnt == c_timeout_last) begin
                        r_tcnt <= '0;
                        r_scnt <= '0;
                        if (r_retry_cnt == c_max_retry) begin
                            r_state <= ST_FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state     <= ST_RETRY;
                            r_pll_rst   <= 1'b1;
                            r_retry_cnt <= r_retry_cnt + 1'b1;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                        r_scnt <= w_lock_s ? (r_scnt + 1'b1) : '0;
                    end
                end

                ST_HOLD: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_tcnt  <= '0;
                        r_scnt  <= '0;
                    end else if (r_tcnt == c_hold_last) begin
                        r_state     <= ST_RUN;
                        r_tcnt      <= '0;
                        r_sys_rst   <= 1'b0;
                        r_ready     <= 1'b1;
                        r_retry_cnt <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (!w_lock_s) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_tcnt      <= '0;
                        r_scnt      <= '0;
                        r_sys_rst   <= 1'b1;
                        r_ready     <= 1'b0;
                        r_lost_lock <= 1'b1;
                    end
                end

                ST_RETRY: begin
                    // The synchronised lock is deliberately not looked at here.
                    if (r_tcnt == c_pulse_last) begin
                        r_state   <= ST_WAIT_LOCK;
                        r_tcnt    <= '0;
                        r_scnt    <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end

                ST_FAIL: begin
                    r_sys_rst <= 1'b1;
                    r_pll_rst <= 1'b0;
                    r_fail    <= 1'b1;
                end

                default: begin
                    r_state   <= ST_WAIT_LOCK;
                    r_tcnt    <= '0;
                    r_scnt    <= '0;
                    r_pll_rst <= 1'b0;
                    r_sys_rst <= 1'b1;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign lost_lock = r_lost_lock;
    assign fail      = r_fail;
    assign retry_cnt = r_retry_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_pll_lock_seq                                                 |
// | Purpose  : Scenario checks plus randomized lock stimulus against a         |
// |            timestamp-based reference model of pll_lock_seq.                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pll_lock_seq;

    localparam int P_SS = 2;
    localparam int P_LS = 8;
    localparam int P_RH = 4;
    localparam int P_TO = 32;
    localparam int P_RP = 3;
    localparam int P_MR = 2;
    localparam int P_RW = 3;

    localparam int EXP_LATENCY = P_SS + P_LS + P_RH;
    localparam int EXP_FAIL_AT = (P_MR + 1) * P_TO + P_MR * P_RP;
    localparam int EXP_LOSS    = P_SS + 1;

    localparam int MODE_WAIT  = 10;
    localparam int MODE_HOLD  = 11;
    localparam int MODE_RUN   = 12;
    localparam int MODE_RETRY = 13;
    localparam int MODE_FAIL  = 14;

    logic            clk;
    logic            rst;
    logic            lock_in;
    logic            pll_rst;
    logic            sys_rst;
    logic            ready;
    logic            lost_lock;
    logic            fail;
    logic [P_RW-1:0] retry_cnt;

    int vectors;
    int miscompares;

    pll_lock_seq #(
        .SYNC_STAGES  (P_SS),
        .LOCK_STABLE  (P_LS),
        .RST_HOLD     (P_RH),
        .LOCK_TIMEOUT (P_TO),
        .RETRY_PULSE  (P_RP),
        .MAX_RETRY    (P_MR),
        .RCNT_W       (P_RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lock_in   (lock_in),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .lost_lock (lost_lock),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: phases tracked by the edge index they began on.
    int edge_no;
    int mode;
    int mode_start;
    int streak_start;
    int retries;
    bit exp_lost;
    bit ls_pipe[$];

    task automatic enter(input int m, input int n);
        mode         = m;
        mode_start   = n + 1;
        streak_start = n + 1;
    endtask

    task automatic model_edge();
        int n;
        bit ls;
        bit qual;
        n        = edge_no;
        exp_lost = 1'b0;
        if (rst) begin
            enter(MODE_WAIT, n);
            retries = 0;
            ls_pipe = {};
            for (int i = 0; i < P_SS; i++) ls_pipe.push_back(1'b0);
            return;
        end
        ls = ls_pipe.pop_front();
        ls_pipe.push_back(lock_in);
        case (mode)
            MODE_WAIT: begin
                qual = ls && (n - streak_start + 1 == P_LS);
                if (!ls) streak_start = n + 1;
                if (qual) begin
                    enter(MODE_HOLD, n);
                end else if (n - mode_start + 1 == P_TO) begin
                    if (retries == P_MR) enter(MODE_FAIL, n);
                    else begin
                        retries++;
                        enter(MODE_RETRY, n);
                    end
                end
            end
            MODE_HOLD: begin
                if (!ls) enter(MODE_WAIT, n);
                else if (n - mode_start + 1 == P_RH) begin
                    enter(MODE_RUN, n);
                    retries = 0;
                end
            end
            MODE_RUN: begin
                if (!ls) begin
                    enter(MODE_WAIT, n);
                    exp_lost = 1'b1;
                end
            end
            MODE_RETRY: begin
                if (n - mode_start + 1 == P_RP) enter(MODE_WAIT, n);
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        model_edge();
        edge_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        lock_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_until_ready(input int budget, output int k);
        k = 0;
        while (!ready && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 6;
        if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL reset_sys_rst got %b want 1", sys_rst); end
        if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready); end
        if (pll_rst !== 1'b0) begin miscompares++; $display("FAIL reset_pll_rst got %b want 0", pll_rst); end
        if (lost_lock !== 1'b0) begin miscompares++; $display("FAIL reset_lost_lock got %b want 0", lost_lock); end
        if (fail !== 1'b0) begin miscompares++; $display("FAIL reset_fail got %b want 0", fail); end
        if (retry_cnt !== '0) begin miscompares++; $display("FAIL reset_retry_cnt got %0d want 0", retry_cnt); end
    endtask

    task automatic test_clean_lock();
        int k;
        bit saw_pll;
        do_reset();
        lock_in = 1'b1;
        k = 0;
        saw_pll = 1'b0;
        while (!ready && k < 40) begin
            tick();
            k++;
            if (pll_rst) saw_pll = 1'b1;
        end
        vectors += 3;
        if (k != EXP_LATENCY) begin miscompares++; $display("FAIL clean_latency got %0d want %0d", k, EXP_LATENCY); end
        if (sys_rst !== 1'b0) begin miscompares++; $display("FAIL clean_sys_rst got %b want 0", sys_rst); end
        if (saw_pll) begin miscompares++; $display("FAIL clean_pll_rst got 1 want 0"); end
    endtask

    task automatic test_glitch();
        int k;
        do_reset();
        lock_in = 1'b1;
        repeat (5) tick();
        lock_in = 1'b0;
        tick();
        lock_in = 1'b1;
        run_until_ready(40, k);
        vectors++;
        if (k != EXP_LATENCY) begin miscompares++; $display("FAIL glitch_latency got %0d want %0d", k, EXP_LATENCY); end
    endtask

    task automatic test_timeout_retry();
        int k;
        int w;
        do_reset();
        k = 0;
        while (!pll_rst && k < 100) begin tick(); k++; end
        vectors += 2;
        if (k != P_TO) begin miscompares++; $display("FAIL retry_timeout got %0d want %0d", k, P_TO); end
        if (retry_cnt !== 3'd1) begin miscompares++; $display("FAIL retry_cnt1 got %0d want 1", retry_cnt); end
        w = 0;
        while (pll_rst && w < 20) begin tick(); w++; end
        vectors++;
        if (w != P_RP) begin miscompares++; $display("FAIL retry_width got %0d want %0d", w, P_RP); end
        lock_in = 1'b1;
        run_until_ready(60, k);
        vectors += 2;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL retry_relock got %b want 1", ready); end
        if (retry_cnt !== '0) begin miscompares++; $display("FAIL retry_cnt_run got %0d want 0", retry_cnt); end
    endtask

    task automatic test_fail();
        int k;
        int pulses;
        bit prev;
        bit late_pll;
        do_reset();
        k = 0;
        pulses = 0;
        prev = 1'b0;
        while (!fail && k < 300) begin
            tick();
            k++;
            if (pll_rst && !prev) pulses++;
            prev = pll_rst;
        end
        vectors += 3;
        if (k != EXP_FAIL_AT) begin miscompares++; $display("FAIL fail_time got %0d want %0d", k, EXP_FAIL_AT); end
        if (pulses != P_MR) begin miscompares++; $display("FAIL fail_pulses got %0d want %0d", pulses, P_MR); end
        if (sys_rst !== 1'b1) begin miscompares++; $display("FAIL fail_sys_rst got %b want 1", sys_rst); end
        late_pll = 1'b0;
        lock_in = 1'b1;
        repeat (50) begin tick(); if (pll_rst) late_pll = 1'b1; end
        vectors += 2;
        if (late_pll) begin miscompares++; $display("FAIL fail_no_pll got 1 want 0"); end
        if (fail !== 1'b1) begin miscompares++; $display("FAIL fail_sticky got %b want 1", fail); end
        do_reset();
        vectors++;
        if (fail !== 1'b0) begin miscompares++; $display("FAIL fail_cleared got %b want 0", fail); end
    endtask

    task automatic test_loss_in_run();
        int k;
        do_reset();
        lock_in = 1'b1;
        run_until_ready(40, k);
        lock_in = 1'b0;
        k = 0;
        while (!sys_rst && k < 10) begin tick(); k++; end
        vectors += 3;
        if (k != EXP_LOSS) begin miscompares++; $display("FAIL loss_latency got %0d want %0d", k, EXP_LOSS); end
        if (lost_lock !== 1'b1) begin miscompares++; $display("FAIL loss_pulse got %b want 1", lost_lock); end
        if (ready !== 1'b0) begin miscompares++; $display("FAIL loss_ready got %b want 0", ready); end
        tick();
        vectors++;
        if (lost_lock !== 1'b0) begin miscompares++; $display("FAIL loss_pulse_width got %b want 0", lost_lock); end
    endtask

    task automatic test_loss_in_hold();
        bit saw_lost;
        bit saw_ready;
        do_reset();
        lock_in = 1'b1;
        repeat (P_SS + P_LS + 1) tick();
        lock_in = 1'b0;
        saw_lost  = 1'b0;
        saw_ready = 1'b0;
        repeat (12) begin
            tick();
            if (lost_lock) saw_lost = 1'b1;
            if (ready) saw_ready = 1'b1;
        end
        vectors += 2;
        if (saw_lost) begin miscompares++; $display("FAIL hold_loss_lost_lock got 1 want 0"); end
        if (saw_ready) begin miscompares++; $display("FAIL hold_loss_ready got 1 want 0"); end
    endtask

    task automatic test_reset_in_retry();
        int k;
        do_reset();
        k = 0;
        while (!pll_rst && k < 100) begin tick(); k++; end
        tick();
        vectors++;
        if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL rr_pulse2 got %b want 1", pll_rst); end
        rst = 1'b1;
        tick();
        vectors += 3;
        if (pll_rst !== 1'b0) begin miscompares++; $display("FAIL rr_pll_rst got %b want 0", pll_rst); end
        if (sys_rst !== 1'b1 || ready !== 1'b0) begin miscompares++; $display("FAIL rr_sys_ready got %b/%b want 1/0", sys_rst, ready); end
        if (retry_cnt !== '0 || fail !== 1'b0) begin miscompares++; $display("FAIL rr_cnt_fail got %0d/%b want 0/0", retry_cnt, fail); end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int seg;
        logic [P_RW+4:0] got;
        logic [P_RW+4:0] want;
        do_reset();
        seg = 0;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                lock_in = ~lock_in;
                seg = lock_in ? $urandom_range(1, 30) : $urandom_range(1, 70);
            end
            seg--;
            rst = ($urandom_range(0, 299) == 0);
            tick();
            got  = {sys_rst, ready, pll_rst, lost_lock, fail, retry_cnt};
            want = {(mode != MODE_RUN), (mode == MODE_RUN), (mode == MODE_RETRY),
                    exp_lost, (mode == MODE_FAIL), P_RW'(retries)};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL random_cycle%0d got sys/rdy/pll/lost/fail/cnt=%b want %b", c, got, want);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        edge_no     = 0;
        retries     = 0;
        mode        = MODE_WAIT;
        mode_start  = 0;
        streak_start = 0;
        exp_lost    = 1'b0;
        rst         = 1'b1;
        lock_in     = 1'b0;
        test_reset();
        test_clean_lock();
        test_glitch();
        test_timeout_retry();
        test_fail();
        test_loss_in_run();
        test_loss_in_hold();
        test_reset_in_retry();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
